// File: rtl/flp_pkg.sv
// Shared packed-float format for the FP add front end: field widths and field extract helpers.
// Default format is IEEE single precision with two guard/round bits below the fraction.
package flp_pkg;

    localparam int EWIDTH  = 8;
    localparam int SWIDTH  = 23;
    localparam int RSWIDTH = 2;
    localparam int FWIDTH  = 1 + EWIDTH + SWIDTH;
    localparam int GWIDTH  = 1 + SWIDTH + RSWIDTH;

    typedef logic [FWIDTH-1:0] flp_t;

    // Operand after unpacking: effective exponent and {hidden,frac,guard/round} significand.
    typedef struct packed {
        logic              sign;
        logic [EWIDTH-1:0] exp;
        logic [GWIDTH-1:0] sg;
    } unpacked_t;

    function automatic logic fp_sign(input flp_t f);
        return f[FWIDTH-1];
    endfunction

    function automatic logic [EWIDTH-1:0] fp_exp(input flp_t f);
        return f[FWIDTH-2 -: EWIDTH];
    endfunction

    function automatic logic [SWIDTH-1:0] fp_frac(input flp_t f);
        return f[SWIDTH-1:0];
    endfunction

endpackage

// File: rtl/flp_align_if.sv
// Operand-in / aligned-operands-out bus of flp_align. The slave modport is the aligner,
// the master modport is whoever feeds operands and consumes aligned results.
interface flp_align_if;

    logic [flp_pkg::FWIDTH-1:0] i_a;
    logic [flp_pkg::FWIDTH-1:0] i_b;
    logic                       i_valid;
    logic                       o_ready;
    logic                       o_sign_l;
    logic                       o_sign_s;
    logic [flp_pkg::EWIDTH-1:0] o_exp;
    logic [flp_pkg::GWIDTH-1:0] o_sg_l;
    logic [flp_pkg::GWIDTH-1:0] o_sg_s;
    logic                       o_swap;
    logic                       o_valid;
    logic                       i_ready;

    modport slave (
        input  i_a, i_b, i_valid, i_ready,
        output o_ready, o_sign_l, o_sign_s, o_exp, o_sg_l, o_sg_s, o_swap, o_valid
    );

    modport master (
        output i_a, i_b, i_valid, i_ready,
        input  o_ready, o_sign_l, o_sign_s, o_exp, o_sg_l, o_sg_s, o_swap, o_valid
    );

endinterface

// File: rtl/flp_shrjam_var.sv
// Combinational variable right shift with sticky jamming: every bit shifted out is ORed
// into the result LSB. Shift amounts of W or more leave only the sticky bit.
module flp_shrjam_var #(
    parameter int W  = 26,
    parameter int AW = 8
) (
    input  logic [W-1:0]  din,
    input  logic [AW-1:0] amt,
    output logic [W-1:0]  dout
);

    logic [W-1:0] shifted;
    logic [W-1:0] lost_mask;

    always_comb begin
        shifted   = '0;
        lost_mask = '0;
        dout      = '0;
        if (int'(amt) >= W) begin
            dout = {{(W-1){1'b0}}, |din};
        end else begin
            shifted   = din >> amt;
            lost_mask = ~({W{1'b1}} << amt);
            dout      = shifted | {{(W-1){1'b0}}, |(din & lost_mask)};
        end
    end

endmodule

// File: rtl/flp_align.sv
// Two-stage pre-add aligner: S1 unpacks and orders operands by exponent, S2 shifts the
// smaller significand right with sticky jam. FLP_ALIGN_SUBNORM_EN enables subnormal inputs.
module flp_align
    import flp_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    flp_align_if.slave bus
);

    function automatic unpacked_t unpack(input flp_t f);
        unpacked_t u;
        u.sign = fp_sign(f);
`ifdef FLP_ALIGN_SUBNORM_EN
        // Subnormals sit at exponent 1 with no hidden bit.
        if (fp_exp(f) == '0) begin
            u.exp = EWIDTH'(1);
            u.sg  = {1'b0, fp_frac(f), {RSWIDTH{1'b0}}};
        end else begin
            u.exp = fp_exp(f);
            u.sg  = {1'b1, fp_frac(f), {RSWIDTH{1'b0}}};
        end
`else
        if (fp_exp(f) == '0) begin
            u.exp = '0;
            u.sg  = '0;
        end else begin
            u.exp = fp_exp(f);
            u.sg  = {1'b1, fp_frac(f), {RSWIDTH{1'b0}}};
        end
`endif
        return u;
    endfunction

    unpacked_t         ua;
    unpacked_t         ub;
    logic              swap_in;
    logic [EWIDTH-1:0] diff_in;

    assign ua      = unpack(bus.i_a);
    assign ub      = unpack(bus.i_b);
    // Ordering uses raw exponents; the effective exponents never reverse that order.
    assign swap_in = fp_exp(bus.i_b) > fp_exp(bus.i_a);
    assign diff_in = swap_in ? (ub.exp - ua.exp) : (ua.exp - ub.exp);

    // Handshake: a transfer happens on a clock edge where valid and ready are both high.
    // S2 advances when it is empty or downstream takes its word (i_ready); S1 advances
    // (and o_ready is high) when S1 is empty or S2 advances. Data never passes i->o comb.
    logic s1_valid;
    logic s2_adv;
    logic accept;

    assign s2_adv      = !bus.o_valid || bus.i_ready;
    assign bus.o_ready = !s1_valid || s2_adv;
    assign accept      = bus.i_valid && bus.o_ready;

    logic              s1_sign_l;
    logic              s1_sign_s;
    logic [EWIDTH-1:0] s1_exp;
    logic [GWIDTH-1:0] s1_sg_l;
    logic [GWIDTH-1:0] s1_sg_s;
    logic [EWIDTH-1:0] s1_diff;
    logic              s1_swap;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_valid  <= 1'b0;
            s1_sign_l <= 1'b0;
            s1_sign_s <= 1'b0;
            s1_exp    <= '0;
            s1_sg_l   <= '0;
            s1_sg_s   <= '0;
            s1_diff   <= '0;
            s1_swap   <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid  <= 1'b1;
                s1_sign_l <= swap_in ? ub.sign : ua.sign;
                s1_sign_s <= swap_in ? ua.sign : ub.sign;
                s1_exp    <= swap_in ? ub.exp  : ua.exp;
                s1_sg_l   <= swap_in ? ub.sg   : ua.sg;
                s1_sg_s   <= swap_in ? ua.sg   : ub.sg;
                s1_diff   <= diff_in;
                s1_swap   <= swap_in;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    logic [GWIDTH-1:0] sg_s_aligned;

    flp_shrjam_var #(
        .W  (GWIDTH),
        .AW (EWIDTH)
    ) u_shrjam (
        .din  (s1_sg_s),
        .amt  (s1_diff),
        .dout (sg_s_aligned)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bus.o_valid  <= 1'b0;
            bus.o_sign_l <= 1'b0;
            bus.o_sign_s <= 1'b0;
            bus.o_exp    <= '0;
            bus.o_sg_l   <= '0;
            bus.o_sg_s   <= '0;
            bus.o_swap   <= 1'b0;
        end else if (s2_adv) begin
            bus.o_valid <= s1_valid;
            if (s1_valid) begin
                bus.o_sign_l <= s1_sign_l;
                bus.o_sign_s <= s1_sign_s;
                bus.o_exp    <= s1_exp;
                bus.o_sg_l   <= s1_sg_l;
                bus.o_sg_s   <= sg_s_aligned;
                bus.o_swap   <= s1_swap;
            end
        end
    end

endmodule
